// File: rtl/apb_master_bridge.sv
// apb_master_bridge: APB3 requester for single-beat local commands.
// Each accepted command becomes one SETUP/ACCESS transfer and produces
// exactly one response pulse. An optional wait-state timeout aborts a
// transfer whose slave never raises pready.
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              prst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              pselx,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [DATA_W-1:0] prdata
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_psel, w_psel_nxt;
  logic                r_pen, w_pen_nxt;
  logic                r_pwrite, w_pwrite_nxt;
  logic [ADDR_W-1:0]   r_paddr, w_paddr_nxt;
  logic [DATA_W-1:0]   r_pwdata, w_pwdata_nxt;
  logic                r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
  logic                r_rsp_err, w_rsp_err_nxt;
  logic                r_rsp_to, w_rsp_to_nxt;
  logic                w_cmd_ready;
  logic                w_to_hit;

  assign w_cmd_ready = (r_state == S_IDLE) && prst_n;
  // The timeout fires on the last permitted wait cycle; TIMEOUT=0 disables it.
  assign w_to_hit    = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  assign cmd_ready   = w_cmd_ready;
  assign pselx       = r_psel;
  assign penable     = r_pen;
  assign pwrite      = r_pwrite;
  assign paddr       = r_paddr;
  assign pwdata      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_to;

  // State, wait counter and all registered outputs.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_psel      <= 1'b0;
      r_pen       <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_to    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_psel      <= w_psel_nxt;
      r_pen       <= w_pen_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_to    <= w_rsp_to_nxt;
    end
  end

  // Next-state and next-output decode; response fields hold unless a transfer ends.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_psel_nxt      = r_psel;
    w_pen_nxt       = r_pen;
    w_pwrite_nxt    = r_pwrite;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    w_rsp_to_nxt    = r_rsp_to;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid && w_cmd_ready) begin
          w_state_nxt  = S_SETUP;
          w_psel_nxt   = 1'b1;
          w_pen_nxt    = 1'b0;
          w_pwrite_nxt = cmd_write;
          w_paddr_nxt  = cmd_addr;
          w_pwdata_nxt = cmd_write ? cmd_wdata : '0;
        end
      end
      S_SETUP: begin
        w_state_nxt = S_ACCESS;
        w_pen_nxt   = 1'b1;
        w_cnt_nxt   = '0;
      end
      S_ACCESS: begin
        if (pready) begin
          w_state_nxt     = S_IDLE;
          w_psel_nxt      = 1'b0;
          w_pen_nxt       = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = pslverr;
          w_rsp_to_nxt    = 1'b0;
          w_rsp_rdata_nxt = r_pwrite ? '0 : prdata;
        end else begin
          if (r_cnt != '1) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
          if (w_to_hit) begin
            w_state_nxt     = S_IDLE;
            w_psel_nxt      = 1'b0;
            w_pen_nxt       = 1'b0;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_to_nxt    = 1'b1;
            w_rsp_rdata_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_psel_nxt  = 1'b0;
        w_pen_nxt   = 1'b0;
      end
    endcase
  end

endmodule
